// File: rtl/button_event_multi_if.sv
// Bus between the button event driver (master modport) and the bus master that
// executes its transactions (slave modport).
interface button_event_multi_if #(
  parameter int SLAVE_LEN = 2,
  parameter int ADDR_LEN  = 12,
  parameter int DATA_LEN  = 8
);
  logic [1:0]           instruction;
  logic [SLAVE_LEN-1:0] slave_select;
  logic [ADDR_LEN-1:0]  address;
  logic [DATA_LEN-1:0]  data_out;
  logic [DATA_LEN-1:0]  data_in;
  logic                 rx_done;
  logic                 tx_done;
  logic                 trans_done;

  modport master (
    output instruction, slave_select, address, data_out,
    input  data_in, rx_done, tx_done, trans_done
  );

  modport slave (
    input  instruction, slave_select, address, data_out,
    output data_in, rx_done, tx_done, trans_done
  );
endinterface

// File: rtl/button_event_multi.sv
// Debounced multi-button transaction launcher: queues button presses, issues the
// bound descriptor of each one at a time, supervises completion and shows the last read byte.
module button_event_multi #(
  parameter int                           SLAVE_LEN   = 2,
  parameter int                           ADDR_LEN    = 12,
  parameter int                           DATA_LEN    = 8,
  parameter int                           NUM_BTN     = 4,
  parameter int                           DEB_CYCLES  = 16,
  parameter int                           TIMEOUT     = 1024,
  parameter logic [2*NUM_BTN-1:0]         BTN_INSTR   = {NUM_BTN{2'b10}},
  parameter logic [SLAVE_LEN*NUM_BTN-1:0] BTN_SLAVE   = {NUM_BTN{SLAVE_LEN'(1)}},
  parameter logic [ADDR_LEN*NUM_BTN-1:0]  BTN_ADDR    = '0,
  parameter logic [DATA_LEN*NUM_BTN-1:0]  BTN_DATA    = '0,
  parameter logic [NUM_BTN-1:0]           BTN_AUTOINC = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_BTN-1:0]          buttons,
  button_event_multi_if.master        bus,
  output logic                        busy,
  output logic [NUM_BTN-1:0]          pending,
  output logic [2:0]                  last_btn,
  output logic                        err,
  output logic [6:0]                  display1_pin,
  output logic [6:0]                  display2_pin
);
  localparam int         IDX_W      = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int         DEB_W      = $clog2(DEB_CYCLES + 1);
  localparam int         TMO_W      = $clog2(TIMEOUT + 1);
  localparam logic [1:0] INSTR_IDLE = 2'b00;
  localparam logic [1:0] INSTR_READ = 2'b11;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_GAP = 2'd2} state_t;

  // Active-low seven-segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] bin27(input logic [3:0] v);
    case (v)
      4'h0: bin27 = 7'b1000000;  4'h1: bin27 = 7'b1111001;
      4'h2: bin27 = 7'b0100100;  4'h3: bin27 = 7'b0110000;
      4'h4: bin27 = 7'b0011001;  4'h5: bin27 = 7'b0010010;
      4'h6: bin27 = 7'b0000010;  4'h7: bin27 = 7'b1111000;
      4'h8: bin27 = 7'b0000000;  4'h9: bin27 = 7'b0010000;
      4'hA: bin27 = 7'b0001000;  4'hB: bin27 = 7'b0000011;
      4'hC: bin27 = 7'b1000110;  4'hD: bin27 = 7'b0100001;
      4'hE: bin27 = 7'b0000110;  4'hF: bin27 = 7'b0001110;
      default: bin27 = 7'b1111111;
    endcase
  endfunction

  logic [NUM_BTN-1:0]   r_sync1, r_sync2, r_deb, r_press, r_pending;
  logic [DEB_W-1:0]     r_deb_cnt [NUM_BTN];
  logic [ADDR_LEN-1:0]  r_offset  [NUM_BTN];
  state_t               r_state, w_state_nxt;
  logic [TMO_W-1:0]     r_tmo_cnt;
  logic [IDX_W-1:0]     r_grant, w_grant_idx;
  logic [NUM_BTN-1:0]   w_grant_oh;
  logic                 w_grant_vld, w_done, w_abort;
  logic [1:0]           r_instr, w_instr_nxt;
  logic [SLAVE_LEN-1:0] r_slave, w_slave_nxt;
  logic [ADDR_LEN-1:0]  r_addr, w_addr_nxt;
  logic [DATA_LEN-1:0]  r_data, w_data_nxt;
  logic                 r_busy, w_busy_nxt, r_err;
  logic [2:0]           r_last;
  logic [7:0]           r_rx_val;
  logic [1:0]           w_btn_instr [NUM_BTN];
  logic [SLAVE_LEN-1:0] w_btn_slave [NUM_BTN];
  logic [ADDR_LEN-1:0]  w_btn_addr  [NUM_BTN];
  logic [DATA_LEN-1:0]  w_btn_data  [NUM_BTN];
  logic                 w_unused_ok;

  // Synchronise, debounce and turn a debounced 1->0 transition into a one-cycle press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_deb   <= '1;
      r_press <= '0;
      for (int i = 0; i < NUM_BTN; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= buttons;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NUM_BTN; i++) begin
        r_press[i] <= 1'b0;
        if (r_sync2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
          r_deb[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
          r_press[i]   <= r_deb[i];
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Unpack per-button descriptors; the address already carries the running offset.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      w_btn_instr[i] = BTN_INSTR[2*i +: 2];
      w_btn_slave[i] = BTN_SLAVE[SLAVE_LEN*i +: SLAVE_LEN];
      w_btn_addr[i]  = BTN_ADDR[ADDR_LEN*i +: ADDR_LEN] + r_offset[i];
      w_btn_data[i]  = BTN_DATA[DATA_LEN*i +: DATA_LEN];
    end
  end

  // Lowest pending index wins; completion beats timeout in the same cycle.
  always_comb begin
    w_grant_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      w_grant_idx = r_pending[i] ? IDX_W'(i) : w_grant_idx;
    end
    w_grant_vld = (r_state == S_IDLE) && (|r_pending);
    w_grant_oh  = w_grant_vld ? (NUM_BTN'(1) << w_grant_idx) : '0;
    w_done      = (r_state == S_WAIT) && bus.trans_done;
    w_abort     = (r_state == S_WAIT) && !bus.trans_done && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_state_nxt = S_WAIT; else w_state_nxt = S_IDLE;
      S_WAIT:  if (w_done || w_abort) w_state_nxt = S_GAP; else w_state_nxt = S_WAIT;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered bus outputs.
  always_comb begin
    w_instr_nxt = r_instr;
    w_slave_nxt = r_slave;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_busy_nxt  = r_busy;
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld) begin
          w_instr_nxt = w_btn_instr[w_grant_idx];
          w_slave_nxt = w_btn_slave[w_grant_idx];
          w_addr_nxt  = w_btn_addr[w_grant_idx];
          w_data_nxt  = w_btn_data[w_grant_idx];
          w_busy_nxt  = 1'b1;
        end else begin
          w_instr_nxt = INSTR_IDLE;
          w_busy_nxt  = 1'b0;
        end
      end
      S_WAIT: begin
        if (w_done || w_abort) begin
          w_instr_nxt = INSTR_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        w_instr_nxt = INSTR_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Bus outputs, timeout supervision and completion bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr   <= INSTR_IDLE;
      r_slave   <= SLAVE_LEN'(1);
      r_addr    <= '0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_tmo_cnt <= '0;
      r_grant   <= '0;
      r_last    <= 3'd0;
      r_err     <= 1'b0;
      r_rx_val  <= 8'd0;
    end else begin
      r_instr <= w_instr_nxt;
      r_slave <= w_slave_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_busy  <= w_busy_nxt;
      if (w_grant_vld) begin
        r_grant   <= w_grant_idx;
        r_tmo_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (w_done || w_abort) r_last <= 3'(r_grant);
      if (w_abort) r_err <= 1'b1;
      if (w_done && (r_instr == INSTR_READ)) r_rx_val <= bus.data_in[7:0];
    end
  end

  // Press queue and per-button address offsets; a press in the grant cycle survives the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      for (int i = 0; i < NUM_BTN; i++) r_offset[i] <= '0;
    end else begin
      r_pending <= (r_pending & ~w_grant_oh) | r_press;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (w_done && (r_grant == IDX_W'(i)) && BTN_AUTOINC[i]) r_offset[i] <= r_offset[i] + 1'b1;
      end
    end
  end

  assign bus.instruction  = r_instr;
  assign bus.slave_select = r_slave;
  assign bus.address      = r_addr;
  assign bus.data_out     = r_data;
  assign busy             = r_busy;
  assign pending          = r_pending;
  assign last_btn         = r_last;
  assign err              = r_err;
  assign display1_pin     = bin27(r_rx_val[3:0]);
  assign display2_pin     = bin27(r_rx_val[7:4]);
  assign w_unused_ok      = &{1'b0, bus.rx_done, bus.tx_done, bus.data_in};
endmodule

// File: tb/tb_button_event_multi.sv
// Directed, table-driven bench for button_event_multi: one press-to-completion
// record per row, plus hand-written priority/queue and mid-transaction reset sequences.
module tb_button_event_multi;
  localparam int NB  = 4;
  localparam int DEB = 16;
  localparam int TMO = 64;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_E = 7'b0000110;

  typedef struct {
    int         btn;
    bit         bounce;
    int         delay;     // cycles until trans_done; 0 = never answer
    logic [7:0] din;
    logic [1:0] e_instr;
    logic [1:0] e_slave;
    logic [11:0] e_addr;
    logic [7:0] e_data;
    logic       e_err;
    logic [2:0] e_last;
    logic [6:0] e_d1;
    logic [6:0] e_d2;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] buttons;
  logic          busy;
  logic [NB-1:0] pending;
  logic [2:0]    last_btn;
  logic          err;
  logic [6:0]    display1_pin, display2_pin;
  int            n_tests = 0;
  int            n_fail  = 0;
  vec_t          vecs [8];

  button_event_multi_if #(.SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8)) bus ();

  button_event_multi #(
    .SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8), .NUM_BTN(NB),
    .DEB_CYCLES(DEB), .TIMEOUT(TMO),
    .BTN_INSTR({2'b11, 2'b10, 2'b11, 2'b10}),
    .BTN_SLAVE({2'd3, 2'd2, 2'd1, 2'd1}),
    .BTN_ADDR({12'h010, 12'h300, 12'd186, 12'd186}),
    .BTN_DATA({8'h00, 8'hA5, 8'h00, 8'd77}),
    .BTN_AUTOINC(4'b0010)
  ) dut (
    .clk(clk), .reset(reset), .buttons(buttons), .bus(bus),
    .busy(busy), .pending(pending), .last_btn(last_btn), .err(err),
    .display1_pin(display1_pin), .display2_pin(display2_pin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns the number of negedges until an instruction appears, or -1 after 100.
  task automatic wait_issue(output int n);
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.instruction != 2'b00) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic answer(input int delay, input logic [7:0] din);
    repeat (delay - 1) @(negedge clk);
    bus.data_in    = din;
    bus.trans_done = 1'b1;
    @(negedge clk);
    bus.trans_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n;
    bit   quiet;

    vecs[0] = '{0, 1'b0, 5, 8'h00, 2'b10, 2'd1, 12'd186, 8'd77, 1'b0, 3'd0, SEG_0, SEG_0};
    vecs[1] = '{1, 1'b0, 3, 8'h55, 2'b11, 2'd1, 12'd186, 8'h00, 1'b0, 3'd1, SEG_5, SEG_5};
    vecs[2] = '{1, 1'b0, 2, 8'h56, 2'b11, 2'd1, 12'd187, 8'h00, 1'b0, 3'd1, SEG_6, SEG_5};
    vecs[3] = '{1, 1'b0, 4, 8'h57, 2'b11, 2'd1, 12'd188, 8'h00, 1'b0, 3'd1, SEG_7, SEG_5};
    vecs[4] = '{2, 1'b1, 1, 8'hAA, 2'b10, 2'd2, 12'h300, 8'hA5, 1'b0, 3'd2, SEG_7, SEG_5};
    vecs[5] = '{1, 1'b0, 0, 8'h00, 2'b11, 2'd1, 12'd189, 8'h00, 1'b1, 3'd1, SEG_7, SEG_5};
    vecs[6] = '{1, 1'b0, 2, 8'h3C, 2'b11, 2'd1, 12'd189, 8'h00, 1'b1, 3'd1, SEG_C, SEG_3};
    vecs[7] = '{3, 1'b0, 3, 8'hE9, 2'b11, 2'd3, 12'h010, 8'h00, 1'b1, 3'd3, SEG_9, SEG_E};

    reset = 1'b1;
    buttons = '1;
    bus.data_in = 8'h00;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    bus.trans_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_instr", bus.instruction, 2'b00);
    chk("rst_slave", bus.slave_select, 2'd1);
    chk("rst_addr", bus.address, 12'd0);
    chk("rst_data", bus.data_out, 8'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pending", pending, 4'b0000);
    chk("rst_last", last_btn, 3'd0);
    chk("rst_err", err, 1'b0);
    chk("rst_disp", {display2_pin, display1_pin}, {SEG_0, SEG_0});
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      v = vecs[k];
      if (v.bounce) begin
        quiet = 1'b1;
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (c % 3 == 0) buttons[v.btn] = ~buttons[v.btn];
          if (pending != '0 || bus.instruction != 2'b00) quiet = 1'b0;
        end
        chk("bounce_no_event", quiet, 1'b1);
      end
      @(negedge clk);
      buttons[v.btn] = 1'b0;
      wait_issue(n);
      chk($sformatf("v%0d_issue_seen", k), n > 0, 1'b1);
      if (k == 0) chk("press_latency", n, DEB + 4);
      chk($sformatf("v%0d_instr", k), bus.instruction, v.e_instr);
      chk($sformatf("v%0d_slave", k), bus.slave_select, v.e_slave);
      chk($sformatf("v%0d_addr", k), bus.address, v.e_addr);
      chk($sformatf("v%0d_data", k), bus.data_out, v.e_data);
      chk($sformatf("v%0d_busy", k), busy, 1'b1);
      if (v.delay > 0) begin
        answer(v.delay, v.din);
      end else begin
        repeat (TMO - 1) @(negedge clk);
        chk($sformatf("v%0d_busy_before_timeout", k), busy, 1'b1);
        chk($sformatf("v%0d_addr_held", k), bus.address, v.e_addr);
        @(negedge clk);
      end
      chk($sformatf("v%0d_busy_done", k), busy, 1'b0);
      chk($sformatf("v%0d_instr_done", k), bus.instruction, 2'b00);
      chk($sformatf("v%0d_err", k), err, v.e_err);
      chk($sformatf("v%0d_last", k), last_btn, v.e_last);
      chk($sformatf("v%0d_disp", k), {display2_pin, display1_pin}, {v.e_d2, v.e_d1});
      buttons[v.btn] = 1'b1;
      repeat (25) @(negedge clk);
      chk($sformatf("v%0d_single_issue", k), {pending, bus.instruction}, 6'd0);
    end

    // Buttons 3 and 1 pressed together while button 0 is outstanding.
    @(negedge clk);
    buttons[0] = 1'b0;
    wait_issue(n);
    chk("q_issue0", n > 0, 1'b1);
    buttons[1] = 1'b0;
    buttons[3] = 1'b0;
    repeat (22) @(negedge clk);
    chk("q_pending", pending, 4'b1010);
    chk("q_busy_held", busy, 1'b1);
    chk("q_addr_held", bus.address, 12'd186);
    answer(3, 8'h00);
    wait_issue(n);
    chk("q_first_gap", n, 2);
    chk("q_first_slave", bus.slave_select, 2'd1);
    chk("q_first_addr", bus.address, 12'd190);
    chk("q_pending_after_first", pending, 4'b1000);
    answer(2, 8'h12);
    wait_issue(n);
    chk("q_second_gap", n, 2);
    chk("q_second_slave", bus.slave_select, 2'd3);
    chk("q_second_addr", bus.address, 12'h010);
    answer(2, 8'hC5);
    chk("q_last", last_btn, 3'd3);
    chk("q_disp", {display2_pin, display1_pin}, {SEG_C, SEG_5});
    buttons = '1;
    repeat (25) @(negedge clk);

    // Reset asserted while a transaction is outstanding and another press is queued.
    buttons[2] = 1'b0;
    wait_issue(n);
    chk("r_issue", n > 0, 1'b1);
    buttons[3] = 1'b0;
    repeat (22) @(negedge clk);
    chk("r_pending_before", pending, 4'b1000);
    reset = 1'b1;
    #1;
    chk("r_instr", bus.instruction, 2'b00);
    chk("r_slave", bus.slave_select, 2'd1);
    chk("r_addr", bus.address, 12'd0);
    chk("r_data", bus.data_out, 8'd0);
    chk("r_busy", busy, 1'b0);
    chk("r_pending", pending, 4'b0000);
    chk("r_last", last_btn, 3'd0);
    chk("r_err", err, 1'b0);
    chk("r_disp", {display2_pin, display1_pin}, {SEG_0, SEG_0});
    buttons = '1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    answer(1, 8'hFF);
    chk("r_late_done_busy", busy, 1'b0);
    chk("r_late_done_last", last_btn, 3'd0);
    chk("r_late_done_disp", {display2_pin, display1_pin}, {SEG_0, SEG_0});
    repeat (25) @(negedge clk);
    chk("r_quiet", {pending, bus.instruction}, 6'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/button_event_multi.md
# button_event_multi

Parametrised button-driven bus-master stimulus block: the next generation of the two-button event driver. It serves NUM_BTN active-low push-buttons, each bound to a compile-time transaction descriptor (read or write, slave, base address, data), with optional per-button address auto-increment. It debounces each button, queues presses, issues them one at a time on the master-side bus interface, supervises completion with a timeout, and shows the last read byte on two seven-segment displays through the existing bin27 decoder.

## Interface
- SLAVE_LEN, 2, slave-select width
- ADDR_LEN, 12, address width
- DATA_LEN, 8, data width (≥8)
- NUM_BTN, 4, number of buttons (1..8)
- DEB_CYCLES, 16, consecutive stable samples for a debounced press/release
- TIMEOUT, 1024, max cycles waiting for trans_done
- BTN_INSTR, {NUM_BTN{2'b10}}, packed per-button instruction; button i at [2i+1:2i]; 2'b10 write, 2'b11 read
- BTN_SLAVE, {NUM_BTN{2'd1}}, packed SLAVE_LEN-bit slave per button
- BTN_ADDR, 0, packed ADDR_LEN-bit base address per button
- BTN_DATA, 0, packed DATA_LEN-bit write data per button
- BTN_AUTOINC, 0, NUM_BTN-bit mask; bit i set enables address auto-increment for button i

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- buttons  in  NUM_BTN  raw active-low buttons (asynchronous)
- data_in  in  DATA_LEN  read data from bus master
- rx_done  in  1  read-data strobe (informational, not used for sequencing)
- tx_done  in  1  write-data strobe (informational, not used for sequencing)
- trans_done  in  1  one-cycle transaction-complete pulse
- instruction  out  2  2'b00 idle, 2'b10 write, 2'b11 read
- slave_select  out  SLAVE_LEN  target slave
- address  out  ADDR_LEN  target address
- data_out  out  DATA_LEN  write data
- busy  out  1  high while a transaction is outstanding
- pending  out  NUM_BTN  queued, not yet issued presses
- last_btn  out  3  index of the last completed or aborted button
- err  out  1  sticky timeout flag, cleared only by reset
- display1_pin  out  7  bin27 of rx_val[3:0]
- display2_pin  out  7  bin27 of rx_val[7:4]

## Operation
- Per button: 2-flop synchroniser, then a debounce counter. The debounced level changes only after DEB_CYCLES consecutive equal samples. A falling edge of the debounced level is a press event. Holding a button produces one event only.
- A press event sets pending[i]. A press on a button that is already pending merges with it: no count, no loss.
- FSM states:
  - IDLE: if pending ≠ 0, grant the lowest set index g, clear pending[g], then drive instruction = BTN_INSTR[g], slave_select = BTN_SLAVE[g], address = BTN_ADDR[g] + offset[g] (mod 2^ADDR_LEN), data_out = BTN_DATA[g]. Set busy = 1 and go to WAIT.
  - WAIT: hold all bus outputs stable and count cycles.
    - On trans_done: if the instruction is read, set rx_val ← data_in. If BTN_AUTOINC[g], set offset[g] ← offset[g] + 1 (wraps). Set last_btn ← g and go to GAP.
    - If the count reaches TIMEOUT without trans_done: set err = 1, set last_btn ← g, leave offset and rx_val unchanged, and go to GAP.
  - GAP: one cycle with instruction = 00 and busy = 0, then go to IDLE. This guarantees at least one idle cycle between transactions.
- slave_select, address and data_out keep their last value when idle.
- Reset values: instruction 00, slave_select 1, address 0, data_out 0, busy 0, pending 0, last_btn 0, err 0, rx_val 0 (displays show "0"), all offsets 0, debounced levels released (1), FSM IDLE.

## Timing
- Press latency: the event fires 2 + DEB_CYCLES cycles after a stable low input, and pending[i] is set on the next edge.
- Issue: instruction becomes valid on the edge after IDLE sees pending ≠ 0.
- Completion: busy falls on the edge after trans_done. rx_val updates on that same edge.
- Minimum spacing between two issues is 3 cycles: WAIT ≥1, GAP, IDLE.
- Simultaneous events:
  - trans_done in the timeout cycle: completion wins and err stays unchanged.
  - A press event in the same cycle that its pending bit is granted: the bit stays set and is re-issued later.
  - trans_done while in IDLE or GAP is ignored.
- Asynchronous reset mid-transaction aborts immediately and all outputs return to reset values.

## Test plan
- Reset with NUM_BTN=4, button 0 = write slave 1 addr 186 data 77: hold buttons[0] low for 30 cycles -> exactly one instruction=10, address=186, data_out=77; trans_done after 5 cycles -> busy 0 and instruction 00 on the next edge.
- Button 1 = read addr 186 with autoinc: press three times, each answered with data_in 0x55, 0x56, 0x57 -> addresses 186, 187, 188; rx_val 0x57; display2/display1 show 5/7.
- Press buttons 3 and 1 in the same cycle while a transaction is busy -> pending=1010, then issue order 1 then 3, and ≥1 idle cycle between them.
- Bounce of buttons[2] toggling every 3 cycles for 40 cycles with DEB_CYCLES=16 -> no event. A stable low then gives one event.
- No trans_done -> abort after TIMEOUT cycles: err=1, last_btn=g, offset unchanged. The next press still works and err stays 1.
- Assert reset during WAIT -> all outputs at reset values in the same cycle and pending cleared. A trans_done after reset is ignored.
